alu_operand_issue: RTL and testbench

// - Execute-stage issue buffer directly upstream of the 32-bit ALU (ops ADD/SUB/OR/AND/SLL).
// - Accepts decoded instructions over a valid/ready handshake and holds them in a 2-entry skid buffer.
// - Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB buses.
// - Drives the ALU's A, B and ALUop inputs, plus rd/write-enable sideband, in program order.

---
 rtl/alu_operand_issue.sv | 215 +++++++++++++++++++++
 tb/tb_alu_operand_issue.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// ---------------------------------------------------------------------------
// alu_operand_issue
//
// Issue buffer sitting directly in front of the 32-bit ALU. Decoded
// instructions arrive over a valid/ready handshake and are held in a
// 2-entry skid buffer. Operands are resolved against the EX/MEM and MEM/WB
// result buses when captured. While they wait, held entries keep snooping
// those buses. Entries leave in program order and drive the ALU's A/B/op
// inputs together with the rd/write-enable sideband.
//
// Build option:
//   ALU_FWD_EN  defined   -> forwarding at capture plus snooping of held entries
//               undefined -> operands are the register-file data as captured;
//                            the exmem_*/memwb_* ports are present but ignored
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready is registered)
//   in_rs1_data/idx      source 1 register-file data and index
//   in_rs2_data/idx      source 2 register-file data and index
//   in_rd_idx, in_wr_en  destination sideband
//   in_imm, in_use_imm   sign-extended immediate and B-operand select
//   in_aluop             ALU opcode
//   flush                drop every buffered and incoming instruction
//   exmem_wr/rd/data     EX/MEM result bus
//   memwb_wr/rd/data     MEM/WB result bus
//   out_valid/out_ready  downstream handshake
//   alu_a, alu_b, alu_op ALU operands and opcode
//   out_rd_idx/out_wr_en destination sideband, passed through
//   out_illegal          opcode is 100, 110 or 111
// ---------------------------------------------------------------------------
module alu_operand_issue #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_rs1_data,
  input  logic [DW-1:0]  in_rs2_data,
  input  logic [RW-1:0]  in_rs1_idx,
  input  logic [RW-1:0]  in_rs2_idx,
  input  logic [RW-1:0]  in_rd_idx,
  input  logic [DW-1:0]  in_imm,
  input  logic           in_use_imm,
  input  logic [OPW-1:0] in_aluop,
  input  logic           in_wr_en,
  input  logic           flush,
  input  logic           exmem_wr,
  input  logic [RW-1:0]  exmem_rd,
  input  logic [DW-1:0]  exmem_data,
  input  logic           memwb_wr,
  input  logic [RW-1:0]  memwb_rd,
  input  logic [DW-1:0]  memwb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [RW-1:0]  out_rd_idx,
  output logic           out_wr_en,
  output logic           out_illegal
);

  // Number of entries held
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // One buffered instruction. The source indices and use_imm are kept so
  // the entry can keep matching result buses while it waits.
  typedef struct packed {
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic           use_imm;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
    logic           wr;
    logic           ill;
  } entry_t;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             in_ready_reg;
  entry_t [1:0]     ent_reg;     // slot 0 is the head
  entry_t [1:0]     ent_next;
  entry_t [1:0]     held;        // each slot with its operands refreshed from the buses
  entry_t           cap;         // incoming instruction as it would be captured

  logic             in_xfer;
  logic             out_xfer;
  logic             load0_cap;
  logic             load1_cap;
  logic             shift_up;

  // Resolve one source operand. Index 0 is the zero register and always
  // yields 0; EX/MEM is newer than MEM/WB, so it wins when both match.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx,
                                        input logic [DW-1:0] cur);
    logic [DW-1:0] r;
    r = cur;
    if (idx == '0)
      r = '0;
`ifdef ALU_FWD_EN
    else if (exmem_wr && (exmem_rd == idx))
      r = exmem_data;
    else if (memwb_wr && (memwb_rd == idx))
      r = memwb_data;
`endif
    return r;
  endfunction

`ifndef ALU_FWD_EN
  // Result buses are not consulted in this build.
  logic unused_bus;
  assign unused_bus = ^{exmem_wr, exmem_rd, exmem_data,
                        memwb_wr, memwb_rd, memwb_data};
`endif

  // Re-evaluate a held entry against the buses. The immediate is never
  // forwarded, so B only snoops when it came from rs2.
  function automatic entry_t snoop(input entry_t e);
    entry_t r;
    r   = e;
    r.a = fwd(e.rs1, e.a);
    if (!e.use_imm)
      r.b = fwd(e.rs2, e.b);
    return r;
  endfunction

  assign in_xfer  = in_valid & in_ready_reg;
  assign out_xfer = (state_reg != ST_EMPTY) & out_ready;

  always_comb begin
    cap         = '0;
    cap.rs1     = in_rs1_idx;
    cap.rs2     = in_rs2_idx;
    cap.use_imm = in_use_imm;
    cap.a       = fwd(in_rs1_idx, in_rs1_data);
    cap.b       = in_use_imm ? in_imm : fwd(in_rs2_idx, in_rs2_data);
    cap.op      = in_aluop;
    cap.rd      = in_rd_idx;
    cap.wr      = in_wr_en;
    cap.ill     = (in_aluop == OPW'(3'b100)) || (in_aluop == OPW'(3'b110)) ||
                  (in_aluop == OPW'(3'b111));
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign held[gi] = snoop(ent_reg[gi]);
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (in_xfer) state_next = ST_ONE;
        ST_ONE: begin
          if (out_xfer && !in_xfer)
            state_next = ST_EMPTY;
          else if (in_xfer && !out_xfer)
            state_next = ST_TWO;
        end
        ST_TWO:   if (out_xfer) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // New instruction goes to the head when the buffer is empty or the head is
  // leaving this cycle; otherwise it lands behind the head. When the head
  // leaves with two held, the second entry moves up.
  assign load0_cap = !flush && in_xfer &&
                     ((state_reg == ST_EMPTY) || ((state_reg == ST_ONE) && out_xfer));
  assign load1_cap = !flush && in_xfer && (state_reg == ST_ONE) && !out_xfer;
  assign shift_up  = !flush && out_xfer && (state_reg == ST_TWO);

  always_comb begin
    ent_next[0] = held[0];
    ent_next[1] = held[1];
    if (load0_cap)
      ent_next[0] = cap;
    else if (shift_up)
      ent_next[0] = held[1];
    if (load1_cap)
      ent_next[1] = cap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b0;
      ent_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_TWO);
      ent_reg      <= ent_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (state_reg != ST_EMPTY);
  assign alu_a       = ent_reg[0].a;
  assign alu_b       = ent_reg[0].b;
  assign alu_op      = ent_reg[0].op;
  assign out_rd_idx  = ent_reg[0].rd;
  assign out_wr_en   = ent_reg[0].wr;
  assign out_illegal = ent_reg[0].ill;

endmodule

// File: tb/tb_alu_operand_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_issue
//
// Self-checking bench for alu_operand_issue. A queue-based reference model
// tracks the buffered instructions; every cycle the DUT handshake and head
// outputs are compared against it. Directed vectors come from a table,
// followed by hand-written stall/skid/flush/reset sequences and a randomized
// run. Follows the ALU_FWD_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_alu_operand_issue;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 3;
`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_rs1_data;
  logic [DW-1:0]  in_rs2_data;
  logic [RW-1:0]  in_rs1_idx;
  logic [RW-1:0]  in_rs2_idx;
  logic [RW-1:0]  in_rd_idx;
  logic [DW-1:0]  in_imm;
  logic           in_use_imm;
  logic [OPW-1:0] in_aluop;
  logic           in_wr_en;
  logic           flush;
  logic           exmem_wr;
  logic [RW-1:0]  exmem_rd;
  logic [DW-1:0]  exmem_data;
  logic           memwb_wr;
  logic [RW-1:0]  memwb_rd;
  logic [DW-1:0]  memwb_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [RW-1:0]  out_rd_idx;
  logic           out_wr_en;
  logic           out_illegal;

  always #5 clk = ~clk;

  alu_operand_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_aluop(in_aluop), .in_wr_en(in_wr_en),
    .flush(flush),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd_idx(out_rd_idx), .out_wr_en(out_wr_en), .out_illegal(out_illegal)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [RW-1:0]  i1;
    logic [RW-1:0]  i2;
    logic           ui;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
    logic           wr;
  } ent_t;

  ent_t q[$];
  logic m_rdy;
  logic m_rst;
  int   nvec = 0;
  int   nerr = 0;

  // Value a source register has right now, given the register-file value.
  function automatic logic [DW-1:0] reg_value(input logic [RW-1:0] idx,
                                              input logic [DW-1:0] v);
    if (idx == 0) return '0;
    if (FWD) begin
      if (exmem_wr && exmem_rd == idx) return exmem_data;
      if (memwb_wr && memwb_rd == idx) return memwb_data;
    end
    return v;
  endfunction

  function automatic logic is_illegal(input logic [OPW-1:0] op);
    return (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model with the inputs present at the edge,
  // then compare the DUT a little after the edge.
  task automatic step(output logic in_x);
    logic out_x;
    ent_t e;
    ent_t h;
    @(posedge clk);
    in_x = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_rdy = 1'b0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      in_x  = in_valid && m_rdy;
      out_x = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
        in_x = 1'b0;
        $display("[%0t] flush", $time);
      end else begin
        e.i1 = in_rs1_idx;
        e.i2 = in_rs2_idx;
        e.ui = in_use_imm;
        e.a  = reg_value(in_rs1_idx, in_rs1_data);
        e.b  = in_use_imm ? in_imm : reg_value(in_rs2_idx, in_rs2_data);
        e.op = in_aluop;
        e.rd = in_rd_idx;
        e.wr = in_wr_en;
        for (int i = 0; i < q.size(); i++) begin
          h   = q[i];
          h.a = reg_value(h.i1, h.a);
          if (!h.ui) h.b = reg_value(h.i2, h.b);
          q[i] = h;
        end
        if (out_x) begin
          h = q.pop_front();
          $display("[%0t] issue rd=%0d wr=%0b a=%h b=%h op=%03b", $time,
                   h.rd, h.wr, h.a, h.b, h.op);
        end
        if (in_x) q.push_back(e);
      end
      m_rdy = (q.size() != 2);
    end
    #1;
    if (m_rst) begin
      chk("rst_in_ready",  DW'(in_ready), '0);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_alu_a",     alu_a, '0);
      chk("rst_alu_b",     alu_b, '0);
      chk("rst_alu_op",    DW'(alu_op), '0);
      chk("rst_rd",        DW'(out_rd_idx), '0);
      chk("rst_wr",        DW'(out_wr_en), '0);
      chk("rst_illegal",   DW'(out_illegal), '0);
    end else begin
      chk("in_ready",  DW'(in_ready), DW'(m_rdy));
      chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        chk("alu_a",   alu_a, h.a);
        chk("alu_b",   alu_b, h.b);
        chk("alu_op",  DW'(alu_op), DW'(h.op));
        chk("rd_idx",  DW'(out_rd_idx), DW'(h.rd));
        chk("wr_en",   DW'(out_wr_en), DW'(h.wr));
        chk("illegal", DW'(out_illegal), DW'(is_illegal(h.op)));
      end
    end
  endtask

  task automatic set_in(input logic [RW-1:0] i1, input logic [DW-1:0] d1,
                        input logic [RW-1:0] i2, input logic [DW-1:0] d2,
                        input logic ui, input logic [DW-1:0] imm,
                        input logic [OPW-1:0] op, input logic [RW-1:0] rd,
                        input logic wr);
    in_valid    = 1'b1;
    in_rs1_idx  = i1;
    in_rs1_data = d1;
    in_rs2_idx  = i2;
    in_rs2_data = d2;
    in_use_imm  = ui;
    in_imm      = imm;
    in_aluop    = op;
    in_rd_idx   = rd;
    in_wr_en    = wr;
  endtask

  task automatic clr_bus();
    exmem_wr = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [RW-1:0]  i1;
    logic [RW-1:0]  i2;
    logic [DW-1:0]  d1;
    logic [DW-1:0]  d2;
    logic [DW-1:0]  imm;
    logic           ui;
    logic [OPW-1:0] op;
    logic           exw;
    logic [RW-1:0]  exrd;
    logic [DW-1:0]  exd;
    logic           mww;
    logic [RW-1:0]  mwrd;
    logic [DW-1:0]  mwd;
    logic [DW-1:0]  ea;
    logic [DW-1:0]  eb;
    logic           eill;
  } vec_t;

  vec_t tbl[8];
  logic ix;
  logic hold;

  initial begin
    // i1, i2, d1, d2, imm, ui, op, exw, exrd, exd, mww, mwrd, mwd, ea, eb, eill
    tbl[0] = '{5'd1, 5'd2, 32'd5, 32'd3, 32'd0, 1'b0, 3'b001,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd3, 1'b0};
    tbl[1] = '{5'd4, 5'd2, 32'd0, 32'd3, 32'd0, 1'b0, 3'b000,
               1'b1, 5'd4, 32'h10, 1'b1, 5'd4, 32'h20,
               FWD ? 32'h10 : 32'h0, 32'd3, 1'b0};
    tbl[2] = '{5'd0, 5'd0, 32'h55, 32'h66, 32'd0, 1'b0, 3'b010,
               1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h98, 32'd0, 32'd0, 1'b0};
    tbl[3] = '{5'd3, 5'd9, 32'd1, 32'hAB, 32'd0, 1'b0, 3'b011,
               1'b1, 5'd9, 32'h111, 1'b1, 5'd3, 32'h20,
               FWD ? 32'h20 : 32'd1, FWD ? 32'h111 : 32'hAB, 1'b0};
    tbl[4] = '{5'd7, 5'd4, 32'hC, 32'h3, 32'hFFFF_FFF0, 1'b1, 3'b100,
               1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 32'd0, 32'hC, 32'hFFFF_FFF0, 1'b1};
    tbl[5] = '{5'd31, 5'd30, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 3'b110,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1};
    tbl[6] = '{5'd2, 5'd5, 32'd8, 32'd9, 32'd0, 1'b1, 3'b111,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd8, 32'd0, 1'b1};
    tbl[7] = '{5'd2, 5'd1, 32'd4, 32'd6, 32'd0, 1'b0, 3'b101,
               1'b0, 5'd2, 32'hFFFF, 1'b0, 5'd1, 32'hEEEE, 32'd4, 32'd6, 1'b0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in('0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    in_valid = 1'b0;
    clr_bus();

    // Reset held for two cycles, then released.
    step(ix);
    step(ix);
    rst_n = 1'b1;
    step(ix);
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));
    chk("post_rst_out_valid", DW'(out_valid), '0);

    // Table vectors: one instruction each into an empty buffer.
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_in(tbl[v].i1, tbl[v].d1, tbl[v].i2, tbl[v].d2, tbl[v].ui, tbl[v].imm,
             tbl[v].op, RW'(v), v[0]);
      exmem_wr = tbl[v].exw; exmem_rd = tbl[v].exrd; exmem_data = tbl[v].exd;
      memwb_wr = tbl[v].mww; memwb_rd = tbl[v].mwrd; memwb_data = tbl[v].mwd;
      step(ix);
      chk($sformatf("vec%0d_out_valid", v), DW'(out_valid), DW'(1));
      chk($sformatf("vec%0d_alu_a", v), alu_a, tbl[v].ea);
      chk($sformatf("vec%0d_alu_b", v), alu_b, tbl[v].eb);
      chk($sformatf("vec%0d_alu_op", v), DW'(alu_op), DW'(tbl[v].op));
      chk($sformatf("vec%0d_illegal", v), DW'(out_illegal), DW'(tbl[v].eill));
      in_valid = 1'b0;
      clr_bus();
      step(ix);
    end

    // Stall: two entries fill the buffer, the held head snoops MEM/WB.
    out_ready = 1'b0;
    set_in(5'd1, 32'd5, 5'd6, 32'd1, 1'b0, '0, 3'b000, 5'd7, 1'b1);
    step(ix);
    set_in(5'd2, 32'd9, 5'd3, 32'd4, 1'b0, '0, 3'b010, 5'd8, 1'b1);
    step(ix);
    chk("skid_full_in_ready", DW'(in_ready), '0);
    in_valid = 1'b0;
    memwb_wr = 1'b1; memwb_rd = 5'd6; memwb_data = 32'd7;
    step(ix);
    chk("snoop_alu_b", alu_b, FWD ? 32'd7 : 32'd1);
    clr_bus();
    out_ready = 1'b1;
    step(ix);
    chk("skid_second_alu_a", alu_a, 32'd9);
    step(ix);
    chk("skid_drain_out_valid", DW'(out_valid), '0);
    chk("skid_drain_in_ready", DW'(in_ready), DW'(1));

    // Simultaneous in and out transfer with one entry held.
    set_in(5'd3, 32'h11, 5'd4, 32'h1, 1'b0, '0, 3'b001, 5'd3, 1'b1);
    step(ix);
    set_in(5'd5, 32'h22, 5'd6, 32'h2, 1'b0, '0, 3'b011, 5'd4, 1'b0);
    step(ix);
    chk("swap_out_valid", DW'(out_valid), DW'(1));
    chk("swap_alu_a", alu_a, 32'h22);
    in_valid = 1'b0;
    step(ix);
    chk("swap_drain", DW'(out_valid), '0);

    // Flush with two held and a third instruction offered.
    out_ready = 1'b0;
    set_in(5'd1, 32'hA, 5'd2, 32'hB, 1'b0, '0, 3'b000, 5'd1, 1'b1);
    step(ix);
    set_in(5'd3, 32'hC, 5'd4, 32'hD, 1'b0, '0, 3'b001, 5'd2, 1'b1);
    step(ix);
    set_in(5'd5, 32'hE, 5'd6, 32'hF, 1'b0, '0, 3'b010, 5'd3, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    step(ix);
    chk("flush_out_valid", DW'(out_valid), '0);
    chk("flush_in_ready", DW'(in_ready), DW'(1));
    flush = 1'b0;
    in_valid = 1'b0;
    step(ix);
    chk("flush_no_issue", DW'(out_valid), '0);

    // Reset in the middle of operation.
    out_ready = 1'b0;
    set_in(5'd7, 32'h70, 5'd8, 32'h80, 1'b0, '0, 3'b110, 5'd9, 1'b1);
    step(ix);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step(ix);
    rst_n = 1'b1;
    step(ix);

    // Randomized traffic against the model.
    ix = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      // An offered instruction stays put until it is taken, unless it was
      // dropped by flush or reset.
      hold = in_valid && !ix && !flush && rst_n;
      if (!hold) begin
        set_in(RW'($urandom_range(0, 7)), $urandom, RW'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 3) == 0), $urandom, OPW'($urandom_range(0, 7)),
               RW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      exmem_wr   = 1'($urandom_range(0, 1));
      exmem_rd   = RW'($urandom_range(0, 7));
      exmem_data = $urandom;
      memwb_wr   = 1'($urandom_range(0, 1));
      memwb_rd   = RW'($urandom_range(0, 7));
      memwb_data = $urandom;
      flush      = ($urandom_range(0, 49) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      step(ix);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
